sort_job_controller: RTL and testbench

- Sequences one sort job for the parallel bubble-sort engine.
- Fetches a block of 64-bit words from memory through a single req/ack memory port and streams them into the engine's element store.
- Starts the sort, waits for completion, then writes the sorted words back to the same addresses.
- Sits between the host command registers, the shared memory port and the sort datapath.

---
 rtl/sort_job_controller.sv | 97 +++++++++
 tb/tb_sort_job_controller.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_job_controller.sv
// sort_job_controller: fetches, sorts and writes back one job; SORT_JOB_CTRL_TIMEOUT_EN enables the mem_ack watchdog
module sort_job_controller #(
  parameter int MAX_ELEMS = 64,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic                         start,
  input  logic [63:0]                  no_of_elements,
  input  logic [ADDR_W-1:0]            start_address,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_ack,
  output logic                         load_valid,
  output logic [$clog2(MAX_ELEMS)-1:0] load_idx,
  output logic [DATA_W-1:0]            load_data,
  output logic                         sort_start,
  input  logic                         sort_done,
  output logic [$clog2(MAX_ELEMS)-1:0] unload_idx,
  input  logic [DATA_W-1:0]            unload_data
);
  localparam int IW = $clog2(MAX_ELEMS);
  localparam int CW = IW + 1;
  typedef enum logic [2:0] {IDLE, READ, SORT_WAIT, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic err_q, first_q, over, last, tout;
  assign over = no_of_elements > 64'(MAX_ELEMS);
  assign last = {1'b0, idx} == cnt - CW'(1);
`ifdef SORT_JOB_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) tcnt <= '0;
    else tcnt <= mem_req && !mem_ack ? tcnt + TW'(1) : '0;
  assign tout = mem_req && !mem_ack && tcnt == TW'(TIMEOUT - 1);
`else
  // No watchdog: a request waits for mem_ack forever.
  assign tout = TIMEOUT < 0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start && !over) begin
                   if (no_of_elements == '0) state_nx = DONE;
                   else state_nx = READ;
                 end
      READ:      if (tout) state_nx = IDLE;
                 else if (mem_ack && last) state_nx = SORT_WAIT;
      SORT_WAIT: if (sort_done) state_nx = WRITE;
      WRITE:     if (tout) state_nx = IDLE;
                 else if (mem_ack && last) state_nx = DONE;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state   <= IDLE;
      base    <= '0;
      cnt     <= '0;
      idx     <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state   <= state_nx;
      err_q   <= (state == IDLE && start && over) || tout;
      first_q <= state == READ && state_nx == SORT_WAIT;
      if (state == IDLE && start) begin
        base <= start_address;
        cnt  <= CW'(no_of_elements);
        idx  <= '0;
      end else if ((state == READ || state == WRITE) && mem_ack)
        idx <= last ? '0 : idx + IW'(1);
    end
  assign busy       = state == READ || state == SORT_WAIT || state == WRITE;
  assign done       = state == DONE;
  assign error      = err_q;
  assign mem_req    = state == READ || state == WRITE;
  assign mem_we     = state == WRITE;
  assign mem_addr   = mem_req ? base + ADDR_W'(idx) * ADDR_W'(DATA_W / 8) : '0;
  assign mem_wdata  = mem_we ? unload_data : '0;
  assign load_valid = state == READ && mem_ack;
  assign load_idx   = load_valid ? idx : '0;
  assign load_data  = load_valid ? mem_rdata : '0;
  assign sort_start = first_q;
  assign unload_idx = mem_we ? idx : '0;
endmodule

// File: tb/tb_sort_job_controller.sv
// tb_sort_job_controller: scoreboard bench with memory and sort-engine models around sort_job_controller
module tb_sort_job_controller;
  logic clk = 0, nreset = 0, start = 0;
  logic [63:0] no_of_elements = 0, start_address = 0;
  logic busy, done, error, mem_req, mem_we, load_valid, sort_start;
  logic [63:0] mem_addr, mem_wdata, load_data, unload_data;
  logic [63:0] mem_rdata = 0;
  logic mem_ack = 0, sort_done = 0;
  logic [5:0] load_idx, unload_idx;

  typedef struct packed {logic we; logic [63:0] addr; logic [63:0] data;} txn_t;
  txn_t exp_q[$], obs_q[$];
  logic [5:0] lidx_q[$];
  logic [63:0] vals[$];
  logic [63:0] mem [logic [63:0]];
  logic [63:0] slots [64];
  int ack_delay, eng_delay, jn, wcnt, sd_cnt, unstable, starts, dones, errors, reqs;
  bit ack_never, force_done, pend;
  logic [63:0] pend_addr;
  logic pend_we;
  int pass_cnt = 0, check_cnt = 0;

  always #5 clk = ~clk;

  sort_job_controller #(.TIMEOUT(16)) dut (
    .clk(clk), .nreset(nreset), .start(start), .no_of_elements(no_of_elements),
    .start_address(start_address), .busy(busy), .done(done), .error(error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .load_valid(load_valid), .load_idx(load_idx),
    .load_data(load_data), .sort_start(sort_start), .sort_done(sort_done),
    .unload_idx(unload_idx), .unload_data(unload_data)
  );

  assign unload_data = slots[unload_idx];

  // Memory and engine responder: drives acks/sort_done on negedge, logs traffic 1 ns later.
  always @(negedge clk) begin : responder
    logic [63:0] t;
    if (mem_req) begin
      if (pend && (mem_addr !== pend_addr || mem_we !== pend_we)) unstable++;
      if (!pend) begin pend = 1; pend_addr = mem_addr; pend_we = mem_we; wcnt = 0; end
      if (!ack_never && wcnt >= ack_delay) begin
        mem_ack = 1;
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 64'hDEAD;
        pend = 0;
      end else begin
        mem_ack = 0;
        wcnt++;
      end
    end else begin
      if (pend && !ack_never && nreset) unstable++;
      pend = 0;
      mem_ack = 0;
    end
    if (sd_cnt > 0) begin sd_cnt--; sort_done = sd_cnt == 0; end
    else sort_done = force_done;
    #1;
    if (mem_req) reqs++;
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        obs_q.push_back('{we: 1'b1, addr: mem_addr, data: mem_wdata});
        mem[mem_addr] = mem_wdata;
      end else obs_q.push_back('{we: 1'b0, addr: mem_addr, data: mem_rdata});
    end
    if (load_valid) begin slots[load_idx] = load_data; lidx_q.push_back(load_idx); end
    if (sort_start) begin
      starts++;
      for (int i = 0; i < jn; i++)
        for (int j = 0; j + 1 < jn - i; j++)
          if (slots[j] > slots[j+1]) begin t = slots[j]; slots[j] = slots[j+1]; slots[j+1] = t; end
      if (eng_delay == 0) sort_done = 1;
      else sd_cnt = eng_delay;
    end
    if (done) dones++;
    if (error) errors++;
  end

  task automatic clear();
    exp_q.delete(); obs_q.delete(); lidx_q.delete();
    starts = 0; dones = 0; errors = 0; reqs = 0; unstable = 0;
    ack_never = 0; force_done = 0;
  endtask

  task automatic prep(input logic [63:0] b);
    logic [63:0] s[$];
    s = vals;
    s.sort();
    for (int i = 0; i < vals.size(); i++) begin
      mem[b + 64'(8 * i)] = vals[i];
      exp_q.push_back('{we: 1'b0, addr: b + 64'(8 * i), data: vals[i]});
    end
    for (int i = 0; i < s.size(); i++)
      exp_q.push_back('{we: 1'b1, addr: b + 64'(8 * i), data: s[i]});
  endtask

  task automatic launch(input logic [63:0] b, input logic [63:0] n);
    @(negedge clk);
    start = 1; start_address = b; no_of_elements = n;
    jn = n > 64 ? 0 : int'(n);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_end(output bit ok, output int busy_low);
    ok = 0; busy_low = 0;
    for (int c = 0; c < 2000; c++) begin
      #3;
      if (done || error) begin ok = 1; break; end
      if (!busy) busy_low++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    nreset = 0;
    repeat (2) @(negedge clk);
    #3;
    check_cnt++;
    if ({busy, done, error, mem_req, mem_we, load_valid, sort_start} !== 7'b0)
      $display("FAIL reset_ctrl: got %b expected 0", {busy, done, error, mem_req, mem_we, load_valid, sort_start});
    else pass_cnt++;
    check_cnt++;
    if ({mem_addr, mem_wdata, load_data, load_idx, unload_idx} !== '0)
      $display("FAIL reset_data: addr=%h wdata=%h ldata=%h lidx=%0d uidx=%0d expected 0", mem_addr, mem_wdata, load_data, load_idx, unload_idx);
    else pass_cnt++;
    @(negedge clk);
    nreset = 1;
  endtask

  task automatic test_basic();
    bit ok; int bl; txn_t e, o;
    clear(); ack_delay = 0; eng_delay = 2;
    vals = '{64'd9, 64'd3, 64'd7, 64'd1};
    prep(64'h1000);
    launch(64'h1000, 4);
    wait_end(ok, bl);
    check_cnt++;
    if (ok !== 1'b1) $display("FAIL basic_end: got %0b expected 1", ok); else pass_cnt++;
    check_cnt++;
    if (bl !== 0) $display("FAIL basic_busy: busy low %0d cycles expected 0", bl); else pass_cnt++;
    repeat (2) @(negedge clk);
    #3;
    check_cnt++;
    if (starts !== 1 || dones !== 1 || errors !== 0)
      $display("FAIL basic_pulses: starts=%0d dones=%0d errors=%0d expected 1/1/0", starts, dones, errors);
    else pass_cnt++;
    check_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL basic_ntxn: got %0d expected %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      check_cnt++;
      if (o !== e) $display("FAIL basic_txn: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
      else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      check_cnt++;
      if (lidx_q.size() == 0 || lidx_q[0] !== 6'(i)) $display("FAIL basic_lidx: got %0d expected %0d", lidx_q.size() ? lidx_q[0] : 6'h3f, i);
      else pass_cnt++;
      if (lidx_q.size() > 0) void'(lidx_q.pop_front());
    end
  endtask

  task automatic test_zero_oversize();
    clear();
    launch(64'h2000, 0);
    #3;
    check_cnt++;
    if ({done, busy} !== 2'b10) $display("FAIL zero_done: got done=%0b busy=%0b expected 1/0", done, busy); else pass_cnt++;
    @(negedge clk); #3;
    check_cnt++;
    if (done !== 1'b0) $display("FAIL zero_pulse: got %0b expected 0", done); else pass_cnt++;
    launch(64'h2000, 65);
    #3;
    check_cnt++;
    if ({error, busy} !== 2'b10) $display("FAIL over_error: got error=%0b busy=%0b expected 1/0", error, busy); else pass_cnt++;
    repeat (3) @(negedge clk);
    #3;
    check_cnt++;
    if (reqs !== 0 || errors !== 1 || dones !== 1 || busy !== 1'b0)
      $display("FAIL zero_over_traffic: reqs=%0d errors=%0d dones=%0d busy=%0b expected 0/1/1/0", reqs, errors, dones, busy);
    else pass_cnt++;
  endtask

  task automatic test_wait_states();
    bit ok; int bl; txn_t e, o;
    clear(); ack_delay = 3; eng_delay = 1;
    vals = '{64'd5, 64'd2, 64'd8};
    prep(64'h4000);
    launch(64'h4000, 3);
    wait_end(ok, bl);
    check_cnt++;
    if (ok !== 1'b1 || unstable !== 0) $display("FAIL wait_stable: end=%0b unstable=%0d expected 1/0", ok, unstable);
    else pass_cnt++;
    check_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL wait_ntxn: got %0d expected %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      check_cnt++;
      if (o !== e) $display("FAIL wait_txn: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
      else pass_cnt++;
    end
    check_cnt++;
    if (lidx_q.size() !== 3 || lidx_q[0] !== 6'd0 || lidx_q[1] !== 6'd1 || lidx_q[2] !== 6'd2)
      $display("FAIL wait_lidx: got %0d entries expected 0,1,2", lidx_q.size());
    else pass_cnt++;
  endtask

  task automatic test_back_to_back_wrap();
    bit ok; int bl; txn_t e, o;
    clear(); ack_delay = 0; eng_delay = 0;
    vals = '{64'h20, 64'h10};
    prep(64'hFFFF_FFFF_FFFF_FFF8);
    launch(64'hFFFF_FFFF_FFFF_FFF8, 2);
    start = 1; start_address = 64'h5000; no_of_elements = 5; force_done = 1;
    @(negedge clk);
    start = 0; force_done = 0;
    wait_end(ok, bl);
    check_cnt++;
    if (ok !== 1'b1 || done !== 1'b1) $display("FAIL wrap_end: end=%0b done=%0b expected 1/1", ok, done); else pass_cnt++;
    repeat (2) @(negedge clk);
    #3;
    check_cnt++;
    if (starts !== 1 || dones !== 1 || busy !== 1'b0)
      $display("FAIL wrap_pulses: starts=%0d dones=%0d busy=%0b expected 1/1/0", starts, dones, busy);
    else pass_cnt++;
    check_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL wrap_ntxn: got %0d expected %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      check_cnt++;
      if (o !== e) $display("FAIL wrap_txn: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_job();
    bit ok, found; int bl; txn_t e, o;
    clear(); ack_delay = 1; eng_delay = 1; found = 0;
    vals = '{64'd4, 64'd3, 64'd2, 64'd1};
    prep(64'h6000);
    launch(64'h6000, 4);
    for (int c = 0; c < 200; c++) begin
      #3;
      if (mem_req && mem_we && mem_addr == 64'h6010) begin found = 1; break; end
      @(negedge clk);
    end
    check_cnt++;
    if (found !== 1'b1) $display("FAIL rst_reach: got %0b expected 1", found); else pass_cnt++;
    nreset = 0;
    #1;
    check_cnt++;
    if ({busy, done, error, mem_req, mem_we, load_valid, sort_start, mem_addr, mem_wdata} !== '0)
      $display("FAIL rst_async: busy=%0b req=%0b we=%0b addr=%h expected 0", busy, mem_req, mem_we, mem_addr);
    else pass_cnt++;
    reqs = 0;
    repeat (3) @(negedge clk);
    nreset = 1;
    #3;
    check_cnt++;
    if (reqs !== 0) $display("FAIL rst_quiet: got %0d requests expected 0", reqs); else pass_cnt++;
    clear(); sd_cnt = 0;
    vals = '{64'd42};
    prep(64'h7000);
    launch(64'h7000, 1);
    wait_end(ok, bl);
    check_cnt++;
    if (ok !== 1'b1 || dones !== 1) $display("FAIL rst_next: end=%0b dones=%0d expected 1/1", ok, dones); else pass_cnt++;
    check_cnt++;
    if (obs_q.size() !== exp_q.size()) $display("FAIL rst_ntxn: got %0d expected %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      check_cnt++;
      if (o !== e) $display("FAIL rst_txn: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
      else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    int first_req, err_at;
    clear(); ack_never = 1; first_req = -1; err_at = -1;
    launch(64'h8000, 2);
`ifdef SORT_JOB_CTRL_TIMEOUT_EN
    for (int c = 0; c < 100; c++) begin
      #3;
      if (mem_req && first_req < 0) first_req = c;
      if (error) begin err_at = c; break; end
      @(negedge clk);
    end
    check_cnt++;
    if (err_at < 0 || err_at - first_req !== 16) $display("FAIL tout_delay: got %0d expected 16", err_at - first_req);
    else pass_cnt++;
    check_cnt++;
    if ({mem_req, busy, done} !== 3'b0 || dones !== 0)
      $display("FAIL tout_idle: req=%0b busy=%0b dones=%0d expected 0", mem_req, busy, dones);
    else pass_cnt++;
    @(negedge clk); #3;
    check_cnt++;
    if (error !== 1'b0) $display("FAIL tout_pulse: got %0b expected 0", error); else pass_cnt++;
`else
    repeat (40) @(negedge clk);
    #3;
    check_cnt++;
    if ({mem_req, busy} !== 2'b11 || errors !== 0)
      $display("FAIL no_tout_wait: req=%0b busy=%0b errors=%0d expected 1/1/0", mem_req, busy, errors);
    else pass_cnt++;
    nreset = 0;
    @(negedge clk);
    nreset = 1;
`endif
    ack_never = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) slots[i] = '0;
    ack_delay = 0; eng_delay = 1; jn = 0; wcnt = 0; sd_cnt = 0;
    test_reset();
    test_basic();
    test_zero_oversize();
    test_wait_states();
    test_back_to_back_wrap();
    test_reset_mid_job();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
